ims_frame_reader: RTL and testbench

- Upstream address generator and downstream stream adapter for the single-port image memory (registered read, 1-cycle latency, no read enable).
- On `start`, sweeps a raster frame of IMG_W x IMG_H pixels from BASE_ADDR upward.
- Captures each returned word and presents it as a valid/ready pixel stream with frame and line markers to the next processing stage.
- Absorbs downstream backpressure with a 2-entry output buffer and credit-based address issue.

---
 rtl/ims_frame_reader.sv | 184 ++++++++++++++++++
 tb/tb_ims_frame_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ims_frame_reader.sv
// ims_frame_reader: raster address generator for a single-port image memory
// (registered read, 1-cycle latency) feeding a valid/ready pixel stream with
// sof/eol/eof markers. A 2-entry output buffer plus credit-based issue
// absorbs downstream backpressure.
// Optional macro IMS_LOOP_EN: frames repeat back to back until abort.
module ims_frame_reader #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter int                 IMG_W     = 64,
    parameter int                 IMG_H     = 64,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } beat_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] lin, addr_q;
    logic              inflight, if_sof, if_eol, if_eof;
    beat_t             fifo0, fifo1, in_beat;
    logic [1:0]        occ, committed;
    logic              pop, issue, eol_now, last, done_nxt;

    assign pop       = (occ != 2'd0) && m_ready;
    assign eol_now   = (col == COL_LAST);
    assign last      = eol_now && (row == ROW_LAST);
    // Words that will occupy the buffer: what stays after this cycle's pop
    // plus the word returning from memory now. Counting the pop keeps
    // full throughput when downstream is always ready.
    assign committed = occ - {1'b0, pop} + {1'b0, inflight};
    assign in_beat   = '{data: mem_data, sof: if_sof, eol: if_eol, eof: if_eof};

    // Address goes out in the issuing cycle so start->first pixel is 2 cycles.
    assign mem_address = issue ? BASE_ADDR + lin : addr_q;

    assign m_valid = (occ != 2'd0);
    assign m_data  = fifo0.data;
    assign m_sof   = fifo0.sof;
    assign m_eol   = fifo0.eol;
    assign m_eof   = fifo0.eof;
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, issue decision and done pulse.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    issue = 1'b1;
`ifdef IMS_LOOP_EN
                    state_nxt = RUN;
`else
                    state_nxt = last ? DRAIN : RUN;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    issue = (committed < 2'd2);
`ifdef IMS_LOOP_EN
                    // Counters wrap on the last issue and the next frame
                    // streams immediately; done marks each accepted eof.
                    done_nxt = pop && fifo0.eof;
`else
                    if (issue && last) state_nxt = DRAIN;
`endif
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster counters, in-flight tracking and the 2-entry output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            lin      <= '0;
            addr_q   <= BASE_ADDR;
            inflight <= 1'b0;
            if_sof   <= 1'b0;
            if_eol   <= 1'b0;
            if_eof   <= 1'b0;
            fifo0    <= '0;
            fifo1    <= '0;
            occ      <= 2'd0;
            done     <= 1'b0;
        end else begin
            done     <= done_nxt;
            inflight <= issue;
            if (issue) begin
                addr_q <= mem_address;
                if_sof <= (row == '0) && (col == '0);
                if_eol <= eol_now;
                if_eof <= last;
                if (last) begin
                    col <= '0;
                    row <= '0;
                    lin <= '0;
                end else begin
                    lin <= lin + ADDR_W'(1);
                    if (eol_now) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) fifo0 <= in_beat;
                    else             fifo1 <= in_beat;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    fifo0 <= fifo1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        fifo0 <= in_beat;
                    end else begin
                        fifo0 <= fifo1;
                        fifo1 <= in_beat;
                    end
                end
                default: ;
            endcase
            // Abort drops buffered and returning words and rewinds the raster.
            if (abort && state != IDLE) begin
                occ      <= 2'd0;
                inflight <= 1'b0;
                col      <= '0;
                row      <= '0;
                lin      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ims_frame_reader.sv
// Scoreboard bench for ims_frame_reader: 4x2 frame at 0x10 plus a 1x1 frame
// instance. Expected beats are pushed per accepted start and popped by an
// independent monitor on every accepted output beat.
module tb_ims_frame_reader;
    localparam int          W = 4, H = 2, N = W * H;
    localparam logic [31:0] BASE = 32'h10, BASE1 = 32'h20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, m_ready, m_valid, m_sof, m_eol, m_eof, busy, done;
    logic [31:0] mem_address, mem_data, m_data;
    logic        start1, abort1, m_ready1, m_valid1, m_sof1, m_eol1, m_eof1, busy1, done1;
    logic [31:0] mem_address1, mem_data1, m_data1;

    ims_frame_reader #(.DATA_W(32), .ADDR_W(32), .IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_address(mem_address),
        .mem_data(mem_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .busy(busy), .done(done));

    ims_frame_reader #(.DATA_W(32), .ADDR_W(32), .IMG_W(1), .IMG_H(1), .BASE_ADDR(BASE1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .mem_address(mem_address1),
        .mem_data(mem_data1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
        .m_sof(m_sof1), .m_eol(m_eol1), .m_eof(m_eof1), .busy(busy1), .done(done1));

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eol;
        logic        eof;
    } beat_t;

    int          n_cmp = 0, n_bad = 0, ready_mode = 0, cyc = 0, addr_changes = 0;
    logic [31:0] salt, last_addr;
    beat_t       exp_q[$];
    beat_t       cur, prev_b, b;
    logic        exp_done, exp_busy, model_busy, prev_stall, acc, eof_acc;

    function automatic logic [31:0] pix(input logic [31:0] a);
        return a ^ salt;
    endfunction

    // Image memory: registered read, contents derived from the address.
    always @(posedge clk) begin
        mem_data  <= pix(mem_address);
        mem_data1 <= pix(mem_address1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++)
            exp_q.push_back('{d: pix(BASE + 32'(i)), sof: (i == 0),
                              eol: ((i % W) == W - 1), eof: (i == N - 1)});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic quiesce();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (done) got = 1'b1;
            else      tick();
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end else begin
            tick();
        end
    endtask

    // Downstream ready pattern: always, 1-0-0, random, or held low.
    initial begin
        m_ready  = 1'b1;
        m_ready1 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
            cyc++;
        end
    end

    // Monitor: compares accepted beats, done, busy and stall stability.
    initial begin
        exp_done = 1'b0; exp_busy = 1'b0; model_busy = 1'b0; prev_stall = 1'b0;
        last_addr = '0; prev_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_done = 1'b0; exp_busy = 1'b0; model_busy = 1'b0; prev_stall = 1'b0;
                exp_q.delete();
                last_addr = mem_address;
            end else begin
                if (mem_address !== last_addr) addr_changes++;
                last_addr = mem_address;
                cur = '{d: m_data, sof: m_sof, eol: m_eol, eof: m_eof};
                check("done", done, exp_done);
                check("busy", busy, exp_busy);
                if (prev_stall) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_hold", cur, prev_b);
                end
                acc = m_valid && m_ready;
                eof_acc = 1'b0;
                if (acc) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL beat: got unexpected beat %0h expected none", cur);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat", cur, b);
                        eof_acc = b.eof;
                    end
                end
                exp_done = acc && eof_acc && !abort && model_busy;
                if (model_busy && abort) begin
                    model_busy = 1'b0;
                    exp_q.delete();
                end else if (!model_busy && start && !abort) begin
                    model_busy = 1'b1;
                    push_frame();
                end else if (model_busy && eof_acc) begin
`ifdef IMS_LOOP_EN
                    push_frame();
`else
                    model_busy = 1'b0;
`endif
                end
                exp_busy   = model_busy;
                prev_stall = m_valid && !m_ready && !abort;
                prev_b     = cur;
            end
        end
    end

    // Stimulus.
    initial begin
        bit found;
        salt = $urandom;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_addr", mem_address, BASE);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_markers", {m_sof, m_eol, m_eof}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr1", mem_address1, BASE1);
        tick();

        // Basic read at full throughput: first beat 2 cycles after start.
        ready_mode = 0;
        tick();
        pulse_start();
        check("lat1_valid", m_valid, 0);
        tick();
        check("lat2_valid", m_valid, 1);
        for (int i = 0; i < N; i++) begin
            check("thru_valid", m_valid, 1);
            tick();
        end
        check("done_time", done, 1);
        quiesce();

        // Backpressure 1,0,0 pattern, then random backpressure.
        ready_mode = 1;
        pulse_start();
        wait_done(100);
        quiesce();
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            pulse_start();
            wait_done(200);
            quiesce();
        end

        // Full stall: only two addresses go out, pixel 0 held on the output.
        ready_mode = 3;
        tick();
        addr_changes = 0;
        pulse_start();
        repeat (9) tick();
        check("stall_issues", 64'(addr_changes), 2);
        check("stall_head_valid", m_valid, 1);
        check("stall_head", {m_data, m_sof, m_eol, m_eof}, {pix(BASE), 3'b100});
        ready_mode = 0;
        wait_done(100);
        quiesce();

        // Abort while pixel 3 is presented, then restart from pixel 0.
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_valid && m_data == pix(BASE + 32'd3)) found = 1'b1;
            else tick();
        end
        check("abort_found_px3", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        pulse_start();
        tick();
        check("restart_head", {m_valid, m_data, m_sof}, {1'b1, pix(BASE), 1'b1});
        wait_done(100);
        quiesce();

        // Degenerate 1x1 frame.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("one_busy", busy1, 1);
        tick();
        check("one_flags", {m_valid1, m_sof1, m_eol1, m_eof1}, 4'hf);
        check("one_data", m_data1, pix(BASE1));
        tick();
        check("one_done", done1, 1);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        tick();

`ifdef IMS_LOOP_EN
        // Continuous frames with random backpressure, stopped by abort.
        ready_mode = 2;
        pulse_start();
        repeat (3) wait_done(200);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("loop_abort_valid", m_valid, 0);
        check("loop_abort_busy", busy, 0);
        tick();
`else
        check("leftover", 64'(exp_q.size()), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
